// File: rtl/theremin_pitch_mapper.sv
// theremin_pitch_mapper: range-gates distance samples, averages them and quantises the average to a note index
module theremin_pitch_mapper #(
    parameter int MIN_CM         = 5,
    parameter int MAX_CM         = 60,
    parameter int CM_PER_STEP    = 2,
    parameter int AVG_LOG2       = 2,
    parameter int SILENCE_CYCLES = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] distance_cm,
    input  logic        distance_ready,
    output logic [5:0]  note_index,
    output logic        note_valid,
    output logic        gate,
    output logic        busy
);
    localparam int TAPS = 1 << AVG_LOG2;
    localparam int SW   = 16 + AVG_LOG2;
    localparam int CW   = $clog2(SILENCE_CYCLES + 1);
    localparam logic [15:0]       MIN_V    = MIN_CM[15:0];
    localparam logic [15:0]       MAX_V    = MAX_CM[15:0];
    localparam logic [15:0]       STEP_V   = CM_PER_STEP[15:0];
    localparam logic [AVG_LOG2:0] FULL_V   = TAPS[AVG_LOG2:0];
    localparam logic [AVG_LOG2:0] FILL_ONE = 1;
    localparam logic [CW-1:0]     SIL_V    = SILENCE_CYCLES[CW-1:0];
    localparam logic [CW-1:0]     SIL_ONE  = 1;

    typedef enum logic [2:0] {IDLE, ACCUM, AVG, DIV, OUT} state_t;
    state_t state, state_nx;

    logic [15:0]       hold;
    logic              hold_valid;
    logic [15:0]       sample;
    logic [15:0]       win [TAPS];
    logic [AVG_LOG2:0] fill;
    logic [SW-1:0]     sum;
    logic [CW-1:0]     silence;
    logic [15:0]       rem;
    logic [5:0]        quot;
    logic [15:0]       cand;
    logic [15:0]       avg;
    logic              cand_valid, in_range, take, accept, full, expire;

    // IDLE sees a strobe arriving this cycle directly, so the newest value always wins over the held one
    assign cand       = distance_ready ? distance_cm : hold;
    assign cand_valid = distance_ready | hold_valid;
    assign in_range   = (cand >= MIN_V) && (cand <= MAX_V);
    assign take       = (state == IDLE) && cand_valid;
    assign accept     = take && in_range;
    assign full       = (fill == FULL_V);
    assign avg        = 16'(sum >> AVG_LOG2);
    assign expire     = (state != ACCUM) && (silence == SIL_V - SIL_ONE);
    assign busy       = (state != IDLE);

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? ACCUM : IDLE;
            ACCUM:   state_nx = AVG;
            AVG:     state_nx = full ? DIV : IDLE;
            DIV:     state_nx = (rem >= STEP_V) ? DIV : OUT;
            OUT:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // hold register: every strobe is captured, IDLE consumes whatever is pending
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold       <= '0;
            hold_valid <= 1'b0;
            sample     <= '0;
        end else begin
            if (distance_ready) hold <= distance_cm;
            hold_valid <= take ? 1'b0 : cand_valid;
            if (accept) sample <= cand;
        end
    end

    // silence counter saturates; an accumulated sample restarts it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   silence <= '0;
        else if (state == ACCUM)    silence <= '0;
        else if (silence != SIL_V)  silence <= silence + SIL_ONE;
    end

    // window, running sum, divider and note outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TAPS; i++) win[i] <= '0;
            fill       <= '0;
            sum        <= '0;
            rem        <= '0;
            quot       <= '0;
            note_index <= '0;
            note_valid <= 1'b0;
            gate       <= 1'b0;
        end else begin
            note_valid <= 1'b0;
            if (state == ACCUM) begin
                sum <= full ? sum + SW'(sample) - SW'(win[TAPS-1]) : sum + SW'(sample);
                if (!full) fill <= fill + FILL_ONE;
                win[0] <= sample;
                for (int i = 1; i < TAPS; i++) win[i] <= win[i-1];
            end else if (expire) begin
                for (int i = 0; i < TAPS; i++) win[i] <= '0;
                fill <= '0;
                sum  <= '0;
                gate <= 1'b0;
            end
            if (state == AVG) begin
                rem  <= avg - MIN_V;
                quot <= '0;
            end
            if (state == DIV && rem >= STEP_V) begin
                rem  <= rem - STEP_V;
                quot <= quot + 6'd1;
            end
            if (state == OUT) begin
                gate <= 1'b1;
                if (quot != note_index || !gate) begin
                    note_index <= quot;
                    note_valid <= 1'b1;
                end
            end
        end
    end
endmodule
